// File: rtl/stream_mux.sv
// stream_mux: N_CH-input stream multiplexer with forced or round-robin channel
// selection and a single-entry registered output stage. A new word is accepted
// whenever the output register is empty or is being drained in the same cycle,
// so a continuously ready sink sees one word per clock.
module stream_mux #(
  parameter int WIDTH = 8,
  parameter int N_CH  = 2,
  parameter int CNT_W = 16,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic [N_CH-1:0]       in_valid,
  output logic [N_CH-1:0]       in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_ch,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  sel_err,
  output logic [CNT_W-1:0]      xfer_cnt
);

  // Registered state
  logic [WIDTH-1:0] out_data_reg;
  logic [SEL_W-1:0] out_ch_reg;
  logic             out_valid_reg;
  logic [SEL_W-1:0] rr_ptr_reg;
  logic [SEL_W-1:0] rr_ptr_next;
  logic             sel_err_reg;
  logic [CNT_W-1:0] xfer_cnt_reg;

  // Grant path
  logic             sel_ok;
  logic [SEL_W-1:0] rr_grant;
  logic             rr_found;
  int               rr_dist;
  int               rr_best;
  logic [SEL_W-1:0] grant;
  logic             grant_valid;
  logic             grant_in_valid;
  logic [WIDTH-1:0] grant_data;
  logic             space;
  logic             accept;

  // Forced index is only meaningful when it names an existing channel.
  assign sel_ok = (int'(sel) < N_CH);

  // Round-robin search: the requesting channel closest to rr_ptr (going upward
  // with wrap) wins, measured as its circular distance from the pointer.
  always_comb begin
    rr_grant = '0;
    rr_found = 1'b0;
    rr_dist  = 0;
    rr_best  = N_CH;
    for (int k = 0; k < N_CH; k++) begin
      rr_dist = (k + N_CH - int'(rr_ptr_reg)) % N_CH;
      if (in_valid[k] && (rr_dist < rr_best)) begin
        rr_best  = rr_dist;
        rr_grant = SEL_W'(k);
        rr_found = 1'b1;
      end
    end
  end

  // Mode chooses between the forced index and the round-robin winner.
  always_comb begin
    grant       = rr_grant;
    grant_valid = rr_found;
    if (!mode) begin
      grant       = sel;
      grant_valid = sel_ok;
    end
  end

  // Data/valid of the granted channel, built without ever indexing past N_CH-1.
  always_comb begin
    grant_data     = '0;
    grant_in_valid = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      if (grant == SEL_W'(k)) begin
        grant_data     = in_data[k*WIDTH +: WIDTH];
        grant_in_valid = in_valid[k];
      end
    end
  end

  assign space  = !out_valid_reg || out_ready;
  assign accept = rst_n && grant_valid && space && grant_in_valid;

  // Only the granted channel sees ready, and never while reset is asserted.
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ready
    assign in_ready[gi] = rst_n && grant_valid && space && (grant == SEL_W'(gi));
  end

  // Pointer moves past the channel just served, wrapping at N_CH-1.
  assign rr_ptr_next = (grant == SEL_W'(N_CH - 1)) ? '0 : grant + 1'b1;

  // Output register: load on accept, otherwise empty out when drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_reg  <= '0;
      out_ch_reg    <= '0;
      out_valid_reg <= 1'b0;
    end else if (accept) begin
      out_data_reg  <= grant_data;
      out_ch_reg    <= grant;
      out_valid_reg <= 1'b1;
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  // Round-robin pointer tracks every accept, in either mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_reg <= '0;
    end else if (accept) begin
      rr_ptr_reg <= rr_ptr_next;
    end
  end

  // Free-running accept counter, wraps naturally at its width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_cnt_reg <= '0;
    end else if (accept) begin
      xfer_cnt_reg <= xfer_cnt_reg + 1'b1;
    end
  end

  // Sticky error for an out-of-range forced index; cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err_reg <= 1'b0;
    end else if (!mode && !sel_ok) begin
      sel_err_reg <= 1'b1;
    end
  end

  assign out_data  = out_data_reg;
  assign out_ch    = out_ch_reg;
  assign out_valid = out_valid_reg;
  assign sel_err   = sel_err_reg;
  assign xfer_cnt  = xfer_cnt_reg;

endmodule

// File: doc/stream_mux.md
STREAM_MUX -- requirements
Module: stream_mux

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width per channel in bits (>=1).
REQ-002 SHALL have parameter N_CH, default 2, number of input channels (>=2).
REQ-003 SHALL have parameter CNT_W, default 16, width of the transfer counter.
REQ-004 SHALL define SEL_W = clog2(N_CH) as a localparam.
REQ-005 Ports, as name, direction, width and meaning:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- mode  input  1  channel selection: 0 = forced (use sel), 1 = round-robin.
- sel  input  SEL_W  forced channel index; used only when mode = 0.
- in_data  input  N_CH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- in_valid  input  N_CH  per-channel valid.
- in_ready  output  N_CH  per-channel ready.
- out_data  output  WIDTH  registered output data.
- out_ch  output  SEL_W  index of the channel that supplied out_data.
- out_valid  output  1  out_data/out_ch hold a word.
- out_ready  input  1  downstream accepts the word.
- sel_err  output  1  sticky flag: forced sel was out of range.
- xfer_cnt  output  CNT_W  count of accepted input transfers.

Function
REQ-006 SHALL compute a grant index g combinationally every cycle.
REQ-007 When mode = 0, g SHALL equal sel, and g SHALL be valid only if sel < N_CH.
REQ-008 When mode = 1, g SHALL be the first channel k with in_valid[k] = 1, searching upward from rr_ptr and wrapping N_CH-1 -> 0. g SHALL be invalid if no in_valid bit is set.
REQ-009 SHALL define space = !out_valid || out_ready. This is a single-entry output register with full-throughput pass-through.
REQ-010 in_ready[k] SHALL be 1 only when g is valid, k = g and space = 1; it SHALL be 0 for every other channel.
REQ-011 An input transfer (accept) SHALL occur when in_valid[g] && in_ready[g].
REQ-012 On accept, on the next edge:
- out_data <= in_data[g]
- out_ch <= g
- out_valid <= 1
REQ-013 On out_valid && out_ready with no accept in the same cycle, out_valid SHALL clear to 0 on the next edge. out_data and out_ch SHALL hold their values.
REQ-014 A simultaneous downstream drain and accept SHALL replace the word with no bubble, giving one word per cycle.
REQ-015 While out_valid && !out_ready, out_data, out_ch and out_valid SHALL stay stable, and all in_ready bits SHALL be 0.
REQ-016 Latency SHALL be 1 cycle from accept to out_valid.
REQ-017 rr_ptr (SEL_W bits) SHALL advance only on accept, to (g+1) mod N_CH. This includes wrap from N_CH-1 to 0 when N_CH is not a power of two. rr_ptr SHALL also update on accepts made in mode 0.
REQ-018 Changing mode or sel SHALL take effect in the same cycle. A word already held in the output register SHALL be unaffected.
REQ-019 sel_err SHALL be set on any cycle with mode = 0 and sel >= N_CH. It SHALL remain set until reset.
REQ-020 xfer_cnt SHALL increment by 1 on each accept and wrap from 2^CNT_W-1 to 0.
REQ-021 The block SHALL not drop or duplicate words. Each accepted word SHALL appear on the output exactly once.

Reset
REQ-022 When rst_n = 0, the block SHALL immediately (asynchronously) force:
- out_valid = 0, out_data = 0, out_ch = 0
- rr_ptr = 0, sel_err = 0, xfer_cnt = 0
REQ-023 While in reset, all in_ready bits SHALL read 0.
REQ-024 Reset asserted mid-transfer SHALL discard the held word. The first accept after rst_n rises SHALL occur no earlier than the first rising edge with rst_n = 1.

Verification
REQ-025 Forced mode, N_CH=2, WIDTH=8, out_ready=1, mode=0, sel=1, in_valid=2'b11, in_data={8'hA5,8'h3C} -> next cycle out_data=8'hA5, out_ch=1, out_valid=1, in_ready=2'b10, xfer_cnt=1.
REQ-026 Round-robin, N_CH=3, all in_valid=1, out_ready=1, 6 cycles -> out_ch sequence 0,1,2,0,1,2, and xfer_cnt=6.
REQ-027 Backpressure: word 8'h11 held, out_ready=0 for 4 cycles while inputs change -> out_data stays 8'h11, in_ready=0, xfer_cnt unchanged. Then out_ready=1 -> next word loads in the same cycle 8'h11 drains.
REQ-028 Out-of-range: N_CH=3, mode=0, sel=3 -> in_ready=0, no transfers, sel_err=1. sel_err stays 1 after sel=0, until rst_n pulses low.
REQ-029 Async reset: rst_n driven low between clock edges while out_valid=1 -> out_valid=0 and xfer_cnt=0 immediately, without waiting for a clock edge.
REQ-030 Counter wrap: CNT_W=4, 17 accepts -> xfer_cnt=1.
